// File: rtl/bgr_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | bgr_ctrl_pkg : shared types and register map for the BGR controller  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package bgr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PORST  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_READY  = 2'd3
  } bgr_state_e;

  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;
  localparam logic [1:0] PORST_OFS  = 2'd2;
  localparam logic [1:0] SETTLE_OFS = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_START_BIT  = 1;
  localparam int CTRL_IRQEN_BIT  = 2;
  localparam int STATUS_DONE_BIT = 2;

  // Merge a Wishbone write into an existing 32-bit value, byte by byte.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bgr_seq_fsm.sv
// +----------------------------------------------------------------------+
// | bgr_seq_fsm : porst / settle sequencer with length snapshot          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bgr_seq_fsm
  import bgr_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] porst_len_i,
  input  logic [CNT_W-1:0] settle_len_i,
  output logic             porst_o,
  output logic             done_set_o,
  output logic [1:0]       state_o
);

  bgr_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] settle_snap_q;
  logic             porst_q;

  // A zero length still occupies one cycle in its state.
  function automatic logic [CNT_W-1:0] first_cnt(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      settle_snap_q <= '0;
      porst_q       <= 1'b1;
    end else if (abort_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      porst_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (start_i) begin
            state_q       <= ST_PORST;
            cnt_q         <= first_cnt(porst_len_i);
            settle_snap_q <= settle_len_i;
            porst_q       <= 1'b1;
          end
        end
        ST_PORST: begin
          if (cnt_q == '0) begin
            state_q <= ST_SETTLE;
            cnt_q   <= first_cnt(settle_snap_q);
            porst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_READY;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done_set_o = !abort_i && (state_q == ST_SETTLE) && (cnt_q == '0);
  assign porst_o    = porst_q;
  assign state_o    = state_q;

endmodule

`default_nettype wire

// File: rtl/user_bgr_wb_ctrl.sv
// +----------------------------------------------------------------------+
// | user_bgr_wb_ctrl : Wishbone register bank and BGR macro sequencer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module user_bgr_wb_ctrl
  import bgr_ctrl_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR      = 32'h3000_0000,
  parameter int               CNT_W          = 16,
  parameter logic [CNT_W-1:0] PORST_LEN_RST  = CNT_W'(100),
  parameter logic [CNT_W-1:0] SETTLE_LEN_RST = CNT_W'(1000)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        porst_o,
  output logic        bgr_en_o,
  output logic        irq_o,
  output logic [1:0]  state_o
);

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             en_q, en_d;
  logic             irqen_q, irqen_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             irq_q;
  logic [CNT_W-1:0] porst_len_q, porst_len_d;
  logic [CNT_W-1:0] settle_len_q, settle_len_d;

  logic             w_req, w_wr, w_done_clr, w_done_set;
  logic [1:0]       w_reg;
  logic [1:0]       w_state;
  logic [31:0]      w_ctrl32, w_porst32, w_settle32, w_rdata;
  logic [31:0]      w_ctrl_wr, w_porst_wr, w_settle_wr;
  logic             unused_bits;

  // The ack_q term blocks back-to-back acks while cyc&stb stays high.
  assign w_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
  assign w_wr  = w_req & wbs_we_i;
  assign w_reg = wbs_adr_i[3:2];

  always_comb begin
    w_ctrl32                 = '0;
    w_ctrl32[CTRL_EN_BIT]    = en_q;
    w_ctrl32[CTRL_IRQEN_BIT] = irqen_q;
    w_porst32                = '0;
    w_porst32[CNT_W-1:0]     = porst_len_q;
    w_settle32               = '0;
    w_settle32[CNT_W-1:0]    = settle_len_q;
  end

  assign w_ctrl_wr   = apply_sel(w_ctrl32,   wbs_dat_i, wbs_sel_i);
  assign w_porst_wr  = apply_sel(w_porst32,  wbs_dat_i, wbs_sel_i);
  assign w_settle_wr = apply_sel(w_settle32, wbs_dat_i, wbs_sel_i);

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      CTRL_OFS:   w_rdata = w_ctrl32;
      STATUS_OFS: begin
        w_rdata[1:0]            = w_state;
        w_rdata[STATUS_DONE_BIT] = done_q;
      end
      PORST_OFS:  w_rdata = w_porst32;
      SETTLE_OFS: w_rdata = w_settle32;
      default:    w_rdata = '0;
    endcase
  end

  always_comb begin
    en_d         = en_q;
    irqen_d      = irqen_q;
    start_d      = 1'b0;
    porst_len_d  = porst_len_q;
    settle_len_d = settle_len_q;
    w_done_clr   = 1'b0;
    if (w_wr) begin
      case (w_reg)
        CTRL_OFS: begin
          en_d    = w_ctrl_wr[CTRL_EN_BIT];
          irqen_d = w_ctrl_wr[CTRL_IRQEN_BIT];
          start_d = w_ctrl_wr[CTRL_START_BIT] & w_ctrl_wr[CTRL_EN_BIT];
        end
        STATUS_OFS: w_done_clr = wbs_sel_i[0] & wbs_dat_i[STATUS_DONE_BIT];
        PORST_OFS:  porst_len_d  = w_porst_wr[CNT_W-1:0];
        SETTLE_OFS: settle_len_d = w_settle_wr[CNT_W-1:0];
        default: ;
      endcase
    end
    // A completion in the same cycle as a clear wins.
    done_d = (done_q & ~w_done_clr) | w_done_set;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      en_q         <= 1'b0;
      irqen_q      <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
      porst_len_q  <= PORST_LEN_RST;
      settle_len_q <= SETTLE_LEN_RST;
    end else begin
      ack_q        <= w_req;
      dat_q        <= w_req ? w_rdata : '0;
      en_q         <= en_d;
      irqen_q      <= irqen_d;
      start_q      <= start_d;
      done_q       <= done_d;
      irq_q        <= done_q & irqen_q;
      porst_len_q  <= porst_len_d;
      settle_len_q <= settle_len_d;
    end
  end

  bgr_seq_fsm #(
    .CNT_W (CNT_W)
  ) u_seq (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .start_i      (start_q),
    .abort_i      (~en_q),
    .porst_len_i  (porst_len_q),
    .settle_len_i (settle_len_q),
    .porst_o      (porst_o),
    .done_set_o   (w_done_set),
    .state_o      (w_state)
  );

  assign unused_bits = ^{wbs_adr_i[1:0], w_ctrl_wr, w_porst_wr, w_settle_wr};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign bgr_en_o  = en_q;
  assign irq_o     = irq_q;
  assign state_o   = w_state;

endmodule

`default_nettype wire

// File: doc/user_bgr_wb_ctrl.md
Name: user_bgr_wb_ctrl

Overview:
Parametrised Wishbone slave that replaces the fixed-ack stub in the caravel user area. It provides a byte-addressable register bank for the bandgap (BGR) macro and a sequencer FSM that drives the macro's power-on-reset (porst) and enable. The sequencer asserts porst for a programmable time, waits a programmable settle time, then flags READY through a status bit and an interrupt. The block sits between the Wishbone slave port and the analog macro pins.

Parameters:
BASE_ADDR, 32'h3000_0000, address of register 0; only wbs_adr_i[31:4] is compared against BASE_ADDR[31:4].
CNT_W, 16, width of the porst and settle length counters (2..32).
PORST_LEN_RST, 16'd100, reset value of the PORST_LEN register.
SETTLE_LEN_RST, 16'd1000, reset value of the SETTLE_LEN register.

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous, active-high reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
porst_o  out  1  macro power-on reset, active high
bgr_en_o  out  1  macro enable
irq_o  out  1  level interrupt
state_o  out  2  FSM state, for debug and logic-analyzer export

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, porst_o=1, bgr_en_o=0, irq_o=0, state_o=IDLE.
- Register map (byte offset from BASE_ADDR):
  - 0x0 CTRL (RW): [0] bgr_en, [1] start (write-1 pulse, always reads 0), [2] irq_en.
  - 0x4 STATUS: [1:0] state (RO), [2] done (sticky, write-1-to-clear).
  - 0x8 PORST_LEN (RW): [CNT_W-1:0].
  - 0xC SETTLE_LEN (RW): [CNT_W-1:0].
  - Bits outside the defined fields read 0.
- Address decode: a request is valid when cyc&stb and adr[31:4]==BASE_ADDR[31:4]; adr[3:2] selects the register and adr[1:0] is ignored.
- Writes honour wbs_sel_i per byte.
- Requests outside the block's address window are never acked.
- Handshake:
  - wbs_ack_o asserts exactly 1 cycle after a valid request and lasts 1 cycle.
  - The ack register is cleared in the cycle after an ack, so a held cyc&stb produces an ack every second cycle, never 2 in a row.
  - Write side effects occur in the ack cycle.
  - wbs_dat_o holds registered read data during the ack cycle and is 0 otherwise.
- bgr_en_o equals CTRL.bgr_en.
- FSM states: IDLE=0, PORST=1, SETTLE=2, READY=3.
  - IDLE: porst_o=1. A start write with bgr_en=1 (the bgr_en value after the same write) moves to PORST. The counter loads max(PORST_LEN,1)-1 and the SETTLE_LEN value is snapshotted.
  - PORST: porst_o=1; the counter decrements. When the counter is 0, move to SETTLE and load the counter with max(snapshot,1)-1. PORST therefore lasts exactly max(len,1) cycles.
  - SETTLE: porst_o=0. When the counter is 0, move to READY and set done.
  - READY: porst_o=0. A start write re-runs the sequence (goes to PORST).
  - Any state: bgr_en=0 forces IDLE on the next cycle and the counter clears. This abort has priority over every other transition.
- Start writes received in PORST or SETTLE are ignored.
- Writes to the length registers during a sequence take effect on the next sequence, because lengths are latched at entry.
- irq_o = done & irq_en, registered.
- If a W1C of done and a set of done occur in the same cycle, the set wins.
- wb_rst_i asserted mid-sequence returns the block to IDLE with porst_o=1 on the next edge, and all registers return to their reset values.

Decomposition:
- Shared package bgr_ctrl_pkg: FSM state enum (2-bit); register offsets CTRL_OFS, STATUS_OFS, PORST_OFS, SETTLE_OFS; CTRL bit indices.
- Sub-module bgr_seq_fsm: contains the FSM, down-counter and length snapshot. Inputs: start, abort, lengths. Outputs: porst, done_set, state. The top level holds the Wishbone decode and the register bank.

Test Plan:
- Reset, then read all 4 registers -> CTRL=0, STATUS=0, PORST_LEN=100, SETTLE_LEN=1000; porst_o=1; each ack arrives 1 cycle after stb and lasts 1 cycle.
- Write PORST_LEN=3, SETTLE_LEN=5, then CTRL=0x7 -> porst_o stays high for exactly 3 cycles after the ack cycle, then low; state reaches READY 5 cycles later; STATUS=0x7; irq_o=1 one cycle later.
- Write STATUS=0x4 -> done clears and irq_o drops the next cycle; write CTRL=0x7 from READY -> sequence reruns with porst_o=1.
- Mid-PORST: write CTRL=0x0 -> state=IDLE the next cycle, porst_o=1, done stays 0; a start write during SETTLE changes nothing.
- PORST_LEN=0 and SETTLE_LEN=0 -> porst lasts 1 cycle and SETTLE lasts 1 cycle.
- Write with sel=4'b0001 to PORST_LEN carrying 0xFFFF_FF12 -> reads back 0x0064 with its low byte replaced, i.e. 0x0012; a request at BASE_ADDR+0x10 is never acked; holding stb high gives acks on alternating cycles.
